// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble binary to packed BCD, one shift per clock
// Optional BCD_AUTO_EN: start a conversion automatically whenever bin differs from the last accepted value.
module bin2bcd_seq #(
  parameter int IN_W  = 16,
  parameter int NDIG  = 5,
  parameter int CNT_W = 5
) (
  input  logic              CLK1,
  input  logic              arst,
  input  logic [IN_W-1:0]   bin,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] bcd,
  output logic [15:0]       text,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   sh_q, sh_d;
  logic [4*NDIG-1:0] scr_q, scr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4*NDIG-1:0] bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [4*NDIG-1:0] adj;
  logic              req;

`ifdef BCD_AUTO_EN
  logic [IN_W-1:0]   last_bin_q, last_bin_d;
  assign req = start | (bin != last_bin_q);
`else
  assign req = start;
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
`ifdef BCD_AUTO_EN
    last_bin_d = last_bin_q;
`endif
    // Digits >= 5 get +3 so the following shift carries correctly into the next digit.
    adj = scr_q;
    for (int i = 0; i < NDIG; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (req) begin
          sh_d    = bin;
          scr_d   = '0;
          cnt_d   = CNT_W'(IN_W);
          state_d = SHIFT;
`ifdef BCD_AUTO_EN
          last_bin_d = bin;
`endif
        end
      end
      SHIFT: begin
        {scr_d, sh_d} = {adj, sh_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = scr_q;
        ovf_d   = (scr_q >> 16) != '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK1) begin
    if (arst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD_AUTO_EN
      last_bin_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
`ifdef BCD_AUTO_EN
      last_bin_q <= last_bin_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign text = bcd_q[15:0];
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

  logic        CLK1 = 1'b0;
  logic        arst;
  logic [15:0] bin;
  logic        start;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic [15:0] text;
  logic        ovf;
  int          tests = 0;
  int          fails = 0;
  int          dc;

  bin2bcd_seq dut (
    .CLK1(CLK1), .arst(arst), .bin(bin), .start(start),
    .busy(busy), .done(done), .bcd(bcd), .text(text), .ovf(ovf)
  );

  always #5 CLK1 = ~CLK1;

  task automatic step();
    @(posedge CLK1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept at edge k, expect result at edge k+17 and no early done pulse.
  task automatic convert(input string tag, input logic [15:0] v, input logic [19:0] eb, input logic eo);
    bin = v; start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    dc = 0;
    repeat (16) begin
      step();
      if (done) dc++;
    end
    chk({tag, "_early_done"}, 32'(dc), 32'd0);
    chk({tag, "_busy_k16"}, 32'(busy), 32'd1);
    step();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_bcd"}, 32'(bcd), 32'(eb));
    chk({tag, "_text"}, 32'(text), 32'(eb[15:0]));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    step();
    chk({tag, "_done_off"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    arst = 1'b1; bin = '0; start = 1'b0;
    step(); step();
    arst = 1'b0;
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_text", 32'(text), 32'd0);
    chk("rst_flags", {29'd0, busy, done, ovf}, 32'd0);

`ifdef BCD_AUTO_EN
    bin = 16'd321;
    step();
    chk("auto_busy", 32'(busy), 32'd1);
    dc = 0;
    repeat (16) begin step(); if (done) dc++; end
    chk("auto_early", 32'(dc), 32'd0);
    step();
    chk("auto_done", 32'(done), 32'd1);
    chk("auto_bcd", 32'(bcd), 32'h00321);
    dc = 0;
    repeat (40) begin step(); if (done) dc++; end
    chk("auto_hold", 32'(dc), 32'd0);
    chk("auto_hold_bcd", 32'(bcd), 32'h00321);
`else
    dc = 0;
    repeat (5) begin step(); if (busy || done) dc++; end
    chk("idle_hold", 32'(dc), 32'd0);

    convert("c1234", 16'd1234, 20'h01234, 1'b0);
    convert("c65535", 16'd65535, 20'h65535, 1'b1);
    convert("c9999", 16'd9999, 20'h09999, 1'b0);
    convert("c0", 16'd0, 20'h00000, 1'b0);
    convert("c10000", 16'd10000, 20'h10000, 1'b1);

    // Starts during SHIFT (k+3) and DONE (k+17) must be dropped.
    bin = 16'd42; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    bin = 16'd7; start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_bcd_hold", 32'(bcd), 32'h10000);
    dc = 0;
    repeat (13) begin step(); if (done) dc++; end
    chk("ign_early", 32'(dc), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_bcd", 32'(bcd), 32'h00042);
    convert("c7", 16'd7, 20'h00007, 1'b0);

    convert("c1234b", 16'd1234, 20'h01234, 1'b0);
    bin = 16'd500; start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("mid_hold", 32'(bcd), 32'h01234);
    arst = 1'b1;
    step();
    arst = 1'b0;
    chk("arst_bcd", 32'(bcd), 32'd0);
    chk("arst_text", 32'(text), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    dc = 0;
    repeat (20) begin step(); if (done || busy) dc++; end
    chk("arst_quiet", 32'(dc), 32'd0);
    convert("c500", 16'd500, 20'h00500, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
